// File: rtl/multiplicador_booth_pkg.sv
// Shared constants and types for the sequential Booth multiplier.
//  - NDefault / CwDefault: operand width and iteration-counter width (2**Cw > N).
//  - NFrac / NInt: fraction/magnitude split of the operands, shared with the
//    downstream truncation stage (product fraction is 2*NFrac bits).
//  - estado_e: FSM state encoding.
package multiplicador_booth_pkg;

  localparam int unsigned NDefault  = 24;
  localparam int unsigned CwDefault = 5;
  localparam int unsigned NFrac     = NDefault - 1;
  localparam int unsigned NInt      = NDefault - NFrac;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StCalc = 2'b01,
    StFin  = 2'b10
  } estado_e;

endpackage

// File: rtl/multiplicador_booth_if.sv
// Start/done handshake bundle between the tap sequencer (master) and the
// multiplier (slave).
//  start       master -> slave  request, only honoured while the slave is idle
//  Dato_A/B    master -> slave  signed operands, captured on the accepted start
//  Datos_Mult  slave -> master  2N-bit signed product, held between operations
//  done        slave -> master  one-cycle pulse, product valid from this cycle
//  busy        slave -> master  operation in progress
interface multiplicador_booth_if #(
  parameter int unsigned N = 24
) ();

  logic             start;
  logic [N-1:0]     Dato_A;
  logic [N-1:0]     Dato_B;
  logic [2*N-1:0]   Datos_Mult;
  logic             done;
  logic             busy;

  modport master (
    output start,
    output Dato_A,
    output Dato_B,
    input  Datos_Mult,
    input  done,
    input  busy
  );

  modport slave (
    input  start,
    input  Dato_A,
    input  Dato_B,
    output Datos_Mult,
    output done,
    output busy
  );

endinterface

// File: rtl/multiplicador_booth_paso_booth.sv
// One radix-2 Booth step (combinational).
//  acc_i, q_i, q1_i  current {acc, Q, q_1}; acc is N+1 bits
//  m_i               sign-extended multiplicand (N+1 bits)
//  acc_o, q_o, q1_o  {acc, Q, q_1} after add/subtract and arithmetic shift right
module paso_booth #(
  parameter int unsigned N = 24
) (
  input  logic [N:0]   acc_i,
  input  logic [N-1:0] q_i,
  input  logic         q1_i,
  input  logic [N:0]   m_i,
  output logic [N:0]   acc_o,
  output logic [N-1:0] q_o,
  output logic         q1_o
);

  logic [N:0] suma;

  always_comb begin
    suma = acc_i;
    case ({q_i[0], q1_i})
      2'b01:   suma = acc_i + m_i;
      2'b10:   suma = acc_i - m_i;
      default: suma = acc_i;
    endcase
  end

  // Arithmetic shift of the concatenation {suma, Q, q_1}.
  assign acc_o = {suma[N], suma[N:1]};
  assign q_o   = {suma[0], q_i[N-1:1]};
  assign q1_o  = q_i[0];

endmodule

// File: rtl/multiplicador_booth.sv
// Sequential signed radix-2 Booth multiplier, one step per clock.
//  clk    system clock, rising edge
//  reset  synchronous, active-high; cancels any operation in flight
//  bus    slave side of the start/done handshake (operands in, product out)
// Latency from accepted start to done is N+1 clocks; the next start is
// accepted in the cycle where done is high.
module multiplicador_booth
  import multiplicador_booth_pkg::*;
#(
  parameter int unsigned N  = NDefault,
  parameter int unsigned CW = CwDefault
) (
  input  logic                 clk,
  input  logic                 reset,
  multiplicador_booth_if.slave bus
);

  estado_e        state_q, state_d;
  logic [N:0]     m_q, m_d;
  logic [N:0]     acc_q, acc_d;
  logic [N-1:0]   q_q, q_d;
  logic           q1_q, q1_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] prod_q, prod_d;
  logic           done_q, done_d;

  logic [N:0]     acc_step;
  logic [N-1:0]   q_step;
  logic           q1_step;

  paso_booth #(
    .N (N)
  ) u_paso (
    .acc_i (acc_q),
    .q_i   (q_q),
    .q1_i  (q1_q),
    .m_i   (m_q),
    .acc_o (acc_step),
    .q_o   (q_step),
    .q1_o  (q1_step)
  );

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    acc_d   = acc_q;
    q_d     = q_q;
    q1_d    = q1_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    done_d  = 1'b0;
    case (state_q)
      StCalc: begin
        acc_d = acc_step;
        q_d   = q_step;
        q1_d  = q1_step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = StFin;
        end
      end
      StFin: begin
        prod_d  = {acc_q[N-1:0], q_q};
        done_d  = 1'b1;
        state_d = StIdle;
      end
      // StIdle, and the unreachable 2'b11 decoded the same way.
      default: begin
        if (bus.start) begin
          // Extra sign bit keeps -M representable when A is the most negative value.
          m_d     = {bus.Dato_A[N-1], bus.Dato_A};
          q_d     = bus.Dato_B;
          acc_d   = '0;
          q1_d    = 1'b0;
          cnt_d   = CW'(N);
          state_d = StCalc;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      cnt_q   <= '0;
      prod_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      done_q  <= done_d;
    end
  end

  assign bus.Datos_Mult = prod_q;
  assign bus.done       = done_q;
  assign bus.busy       = (state_q == StCalc) || (state_q == StFin);

endmodule

// File: tb/tb_multiplicador_booth.sv
module tb_multiplicador_booth;

  localparam int unsigned N   = 24;
  localparam int          LAT = N + 1;

  logic clk;
  logic reset;
  int   nvec;
  int   nbad;

  multiplicador_booth_if #(.N(N)) bus ();

  multiplicador_booth #(
    .N  (N),
    .CW (5)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic [2*N-1:0] p;
  } vec_t;

  task automatic chk(input string name, input logic [2*N-1:0] got, input logic [2*N-1:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Issue one operation from idle; returns product and latency (edges after acceptance).
  task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b,
                       output logic [2*N-1:0] res, output int lat);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.Dato_A = a;
    bus.Dato_B = b;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.Dato_A = ~a;
    bus.Dato_B = ~b;
    chk("busy_after_start", 48'(bus.busy), 48'd1);
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (bus.done) break;
    end
    res = bus.Datos_Mult;
    chk("busy_at_done", 48'(bus.busy), 48'd0);
    @(negedge clk);
    chk("done_one_cycle", 48'(bus.done), 48'd0);
    chk("prod_held", bus.Datos_Mult, res);
  endtask

  vec_t vecs[10];
  logic [2*N-1:0] res;
  int             lat;
  int             ndone;
  logic [N-1:0]   corners[5];
  logic [N-1:0]   ra, rb;
  logic signed [2*N-1:0] ea, eb, eref;

  initial begin
    nvec = 0;
    nbad = 0;
    vecs[0] = '{24'd3,       24'd5,       48'd15};
    vecs[1] = '{24'hFFFFFF,  24'd1,       48'hFFFF_FFFF_FFFF};
    vecs[2] = '{24'hFFFFF9,  24'hFFFFF7,  48'd63};
    vecs[3] = '{24'h800000,  24'h800000,  48'h4000_0000_0000};
    vecs[4] = '{24'h800000,  24'h7FFFFF,  48'hC000_0080_0000};
    vecs[5] = '{24'd0,       24'h7FFFFF,  48'd0};
    vecs[6] = '{24'h7FFFFF,  24'h7FFFFF,  48'h3FFF_FF00_0001};
    vecs[7] = '{24'hFFFFFF,  24'hFFFFFF,  48'd1};
    vecs[8] = '{24'd1000,    24'hFFFC18,  48'hFFFF_FFF0_BDC0};
    vecs[9] = '{24'd2,       24'hFFFFFD,  48'hFFFF_FFFF_FFFA};

    bus.start  = 1'b0;
    bus.Dato_A = '0;
    bus.Dato_B = '0;
    reset      = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_prod", bus.Datos_Mult, 48'd0);
    chk("reset_done", 48'(bus.done), 48'd0);
    chk("reset_busy", 48'(bus.busy), 48'd0);
    reset = 1'b0;

    // Directed table.
    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].a, vecs[i].b, res, lat);
      chk($sformatf("vec%0d_prod", i), res, vecs[i].p);
      chk($sformatf("vec%0d_lat", i), 48'(lat), 48'(LAT));
    end

    // start held high, operands changed mid-CALC: back-to-back ops, first operands only.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.Dato_A = 24'd3;
    bus.Dato_B = 24'd5;
    ndone = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (c == 5) begin
        bus.Dato_A = 24'hFFFFF9;
        bus.Dato_B = 24'hFFFFF7;
      end
      if (c == LAT + 1) bus.start = 1'b0;
      if (bus.done) begin
        ndone++;
        if (ndone == 1) begin
          chk("held_first_prod", bus.Datos_Mult, 48'd15);
          chk("held_first_cycle", 48'(c), 48'(LAT));
        end else begin
          chk("held_second_prod", bus.Datos_Mult, 48'd63);
          chk("held_second_cycle", 48'(c), 48'(2 * LAT + 1));
        end
      end
    end
    chk("held_done_count", 48'(ndone), 48'd2);

    // Reset at step 10 of CALC cancels the operation.
    @(negedge clk);
    bus.start  = 1'b1;
    bus.Dato_A = 24'd7;
    bus.Dato_B = 24'd9;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_busy", 48'(bus.busy), 48'd0);
    chk("midreset_done", 48'(bus.done), 48'd0);
    chk("midreset_prod", bus.Datos_Mult, 48'd0);
    ndone = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.done) ndone++;
    end
    chk("midreset_no_done", 48'(ndone), 48'd0);
    do_op(24'd7, 24'd9, res, lat);
    chk("after_reset_prod", res, 48'd63);

    // Random pairs with corner values mixed in.
    corners = '{24'd0, 24'h7FFFFF, 24'h800000, 24'hFFFFFF, 24'h800001};
    for (int i = 0; i < 300; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : N'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : N'($urandom);
      ea = {{N{ra[N-1]}}, ra};
      eb = {{N{rb[N-1]}}, rb};
      eref = ea * eb;
      do_op(ra, rb, res, lat);
      chk($sformatf("rand_%h_%h", ra, rb), res, eref);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
